// File: rtl/commit_wb_arbiter_if.sv
// Commit-bundle / register-file write-port bundle for commit_wb_arbiter.
// retire_cnt is present only when RETIRE_CNT_EN is defined.
interface commit_wb_arbiter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 64
);
    logic            i1_valid;
    logic            i1_regwrite;
    logic [AW-1:0]   i1_rd;
    logic [XLEN-1:0] i1_data;
    logic            i2_valid;
    logic            i2_regwrite;
    logic [AW-1:0]   i2_rd;
    logic [XLEN-1:0] i2_data;
    logic            in_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            pend_valid;
    logic [AW-1:0]   pend_rd;
`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
`endif

    // Pipeline side: drives the commit bundle, observes the port and hazard state.
    modport master (
        output i1_valid, i1_regwrite, i1_rd, i1_data,
        output i2_valid, i2_regwrite, i2_rd, i2_data,
        input  in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd
`ifdef RETIRE_CNT_EN
        , input retire_cnt
`endif
    );

    // Arbiter side.
    modport slave (
        input  i1_valid, i1_regwrite, i1_rd, i1_data,
        input  i2_valid, i2_regwrite, i2_rd, i2_data,
        output in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd
`ifdef RETIRE_CNT_EN
        , output retire_cnt
`endif
    );
endinterface

// File: rtl/commit_wb_arbiter.sv
// Serialises a dual-issue commit bundle onto the single integer RF write port,
// resolving same-rd WAW in favour of slot2. Optional retire counter: RETIRE_CNT_EN.
module commit_wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 64
) (
    input logic clk,
    input logic rstn,
    commit_wb_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]      state, state_n;
    logic            rf_we_q, rf_we_n;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_n;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_n;
    logic            pend_valid_q, pend_valid_n;
    logic [AW-1:0]   pend_rd_q, pend_rd_n;
    logic [XLEN-1:0] pend_data_q, pend_data_n;

    logic in_ready_c;
    logic accept_c;
    logic w1_c;
    logic w2_c;

    assign in_ready_c = (state == IDLE);
    assign accept_c   = in_ready_c & (bus.i1_valid | bus.i2_valid);
    assign w2_c = bus.i2_valid & bus.i2_regwrite & (bus.i2_rd != '0);
    // Younger slot wins a same-rd conflict, so the older write is dropped.
    assign w1_c = bus.i1_valid & bus.i1_regwrite & (bus.i1_rd != '0)
                & ~(w2_c & (bus.i1_rd == bus.i2_rd));

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        rf_we_n      = 1'b0;
        rf_waddr_n   = rf_waddr_q;
        rf_wdata_n   = rf_wdata_q;
        pend_valid_n = pend_valid_q;
        pend_rd_n    = pend_rd_q;
        pend_data_n  = pend_data_q;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (w1_c) begin
                        rf_we_n    = 1'b1;
                        rf_waddr_n = bus.i1_rd;
                        rf_wdata_n = bus.i1_data;
                        if (w2_c) begin
                            pend_valid_n = 1'b1;
                            pend_rd_n    = bus.i2_rd;
                            pend_data_n  = bus.i2_data;
                            state_n      = PEND;
                        end
                    end else if (w2_c) begin
                        rf_we_n    = 1'b1;
                        rf_waddr_n = bus.i2_rd;
                        rf_wdata_n = bus.i2_data;
                    end
                end
            end
            PEND: begin
                rf_we_n      = 1'b1;
                rf_waddr_n   = pend_rd_q;
                rf_wdata_n   = pend_data_q;
                pend_valid_n = 1'b0;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            pend_data_q  <= '0;
        end else begin
            state        <= state_n;
            rf_we_q      <= rf_we_n;
            rf_waddr_q   <= rf_waddr_n;
            rf_wdata_q   <= rf_wdata_n;
            pend_valid_q <= pend_valid_n;
            pend_rd_q    <= pend_rd_n;
            pend_data_q  <= pend_data_n;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.pend_valid = pend_valid_q;
    assign bus.pend_rd    = pend_rd_q;

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_n;

    // Counts committed instructions, regardless of whether they write a register.
    always_comb begin
        retire_cnt_n = retire_cnt_q;
        if (accept_c) begin
            retire_cnt_n = retire_cnt_q + CNT_W'(bus.i1_valid) + CNT_W'(bus.i2_valid);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_n;
        end
    end

    assign bus.retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_commit_wb_arbiter.sv
// Directed, table-driven bench for commit_wb_arbiter; each table row is one
// clock cycle of inputs plus the outputs expected just after that edge.
module tb_commit_wb_arbiter;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 64;
    localparam int NV = 18;

    typedef struct {
        logic        i1v;
        logic        i1w;
        logic [4:0]  i1rd;
        logic [31:0] i1d;
        logic        i2v;
        logic        i2w;
        logic [4:0]  i2rd;
        logic [31:0] i2d;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        pv;
        logic [4:0]  prd;
        logic        rdy;
        logic [63:0] cnt;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;
    vec_t vt [NV];

    commit_wb_arbiter_if #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) bus ();

    commit_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i1_valid    = v.i1v;
        bus.i1_regwrite = v.i1w;
        bus.i1_rd       = v.i1rd;
        bus.i1_data     = v.i1d;
        bus.i2_valid    = v.i2v;
        bus.i2_regwrite = v.i2w;
        bus.i2_rd       = v.i2rd;
        bus.i2_data     = v.i2d;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0};
        drive(v);
    endtask

    task automatic check_outs(input int idx, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic pv, input logic [4:0] prd,
                              input logic rdy, input logic [63:0] cnt);
        chk("rf_we",      idx, 64'(bus.rf_we),      64'(we));
        chk("rf_waddr",   idx, 64'(bus.rf_waddr),   64'(wa));
        chk("rf_wdata",   idx, 64'(bus.rf_wdata),   64'(wd));
        chk("pend_valid", idx, 64'(bus.pend_valid), 64'(pv));
        chk("pend_rd",    idx, 64'(bus.pend_rd),    64'(prd));
        chk("in_ready",   idx, 64'(bus.in_ready),   64'(rdy));
`ifdef RETIRE_CNT_EN
        chk("retire_cnt", idx, 64'(bus.retire_cnt), cnt);
`else
        if (cnt === 64'hFFFF_FFFF_FFFF_FFFF) $display("note: count %0d unused", idx);
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //       i1v   i1w   i1rd   i1d            i2v   i2w   i2rd   i2d
        //       we    waddr  wdata          pv    prd    rdy   cnt
        vt[0]  = '{1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,
                   1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  1'b1, 64'd0};
        vt[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  32'd0,
                   1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b1, 64'd1};
        vt[2]  = '{1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,
                   1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b1, 64'd1};
        vt[3]  = '{1'b1, 1'b1, 5'd3,  32'h11,       1'b1, 1'b1, 5'd4,  32'h22,
                   1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  1'b0, 64'd3};
        vt[4]  = '{1'b1, 1'b1, 5'd9,  32'h99,       1'b1, 1'b1, 5'd8,  32'h88,
                   1'b1, 5'd4,  32'h22,       1'b0, 5'd4,  1'b1, 64'd3};
        vt[5]  = '{1'b1, 1'b1, 5'd7,  32'hAAAA,     1'b1, 1'b1, 5'd7,  32'hBBBB,
                   1'b1, 5'd7,  32'hBBBB,     1'b0, 5'd4,  1'b1, 64'd5};
        vt[6]  = '{1'b1, 1'b1, 5'd0,  32'h1234,     1'b1, 1'b1, 5'd0,  32'h5678,
                   1'b0, 5'd7,  32'hBBBB,     1'b0, 5'd4,  1'b1, 64'd7};
        vt[7]  = '{1'b1, 1'b0, 5'd8,  32'h88,       1'b1, 1'b1, 5'd9,  32'h99,
                   1'b1, 5'd9,  32'h99,       1'b0, 5'd4,  1'b1, 64'd9};
        vt[8]  = '{1'b0, 1'b1, 5'd1,  32'h1,        1'b1, 1'b1, 5'd10, 32'hA0,
                   1'b1, 5'd10, 32'hA0,       1'b0, 5'd4,  1'b1, 64'd10};
        vt[9]  = '{1'b1, 1'b1, 5'd11, 32'hB1,       1'b1, 1'b0, 5'd12, 32'hC2,
                   1'b1, 5'd11, 32'hB1,       1'b0, 5'd4,  1'b1, 64'd12};
        vt[10] = '{1'b1, 1'b1, 5'd0,  32'hC3,       1'b1, 1'b1, 5'd13, 32'hD3,
                   1'b1, 5'd13, 32'hD3,       1'b0, 5'd4,  1'b1, 64'd14};
        // Three dual-write bundles offered every cycle; B and C are each held once.
        vt[11] = '{1'b1, 1'b1, 5'd14, 32'h14,       1'b1, 1'b1, 5'd15, 32'h15,
                   1'b1, 5'd14, 32'h14,       1'b1, 5'd15, 1'b0, 64'd16};
        vt[12] = '{1'b1, 1'b1, 5'd16, 32'h16,       1'b1, 1'b1, 5'd17, 32'h17,
                   1'b1, 5'd15, 32'h15,       1'b0, 5'd15, 1'b1, 64'd16};
        vt[13] = '{1'b1, 1'b1, 5'd16, 32'h16,       1'b1, 1'b1, 5'd17, 32'h17,
                   1'b1, 5'd16, 32'h16,       1'b1, 5'd17, 1'b0, 64'd18};
        vt[14] = '{1'b1, 1'b1, 5'd18, 32'h18,       1'b1, 1'b1, 5'd19, 32'h19,
                   1'b1, 5'd17, 32'h17,       1'b0, 5'd17, 1'b1, 64'd18};
        vt[15] = '{1'b1, 1'b1, 5'd18, 32'h18,       1'b1, 1'b1, 5'd19, 32'h19,
                   1'b1, 5'd18, 32'h18,       1'b1, 5'd19, 1'b0, 64'd20};
        vt[16] = '{1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,
                   1'b1, 5'd19, 32'h19,       1'b0, 5'd19, 1'b1, 64'd20};
        vt[17] = '{1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,
                   1'b0, 5'd19, 32'h19,       1'b0, 5'd19, 1'b1, 64'd20};

        rstn = 1'b0;
        drive_idle();
        #2;
        check_outs(-1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i]);
            @(posedge clk);
            #1;
            check_outs(i, vt[i].we, vt[i].waddr, vt[i].wdata, vt[i].pv, vt[i].prd,
                       vt[i].rdy, vt[i].cnt);
        end

        // Reset while a second write is buffered: it must never reach the port.
        @(negedge clk);
        drive('{1'b1, 1'b1, 5'd20, 32'h20, 1'b1, 1'b1, 5'd21, 32'h21,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0});
        @(posedge clk);
        #1;
        check_outs(100, 1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 1'b0, 64'd22);
        #2;
        rstn = 1'b0;
        #1;
        check_outs(101, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0);
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_outs(102, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0);
        @(posedge clk);
        #1;
        check_outs(103, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0);

        // Single write straight after reset release lands with one-cycle latency.
        @(negedge clk);
        drive('{1'b1, 1'b1, 5'd31, 32'hFFFF_0001, 1'b0, 1'b1, 5'd2, 32'h2,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 64'd0});
        @(posedge clk);
        #1;
        check_outs(104, 1'b1, 5'd31, 32'hFFFF_0001, 1'b0, 5'd0, 1'b1, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
